// File: rtl/alu_issue_pkg.sv
// Shared ALU op codes, RV32I decode constants and the decode result type for the ALU issue stage.
// Pure definitions: no latency, no flow control.
package alu_issue_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_imm;
    logic [11:0] imm;
    logic        legal;
  } dec_t;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_SRL) || (f3 == F3_OR) || (f3 == F3_AND);
  endfunction

  function automatic logic [2:0] f3_to_op(input logic [2:0] f3);
    case (f3)
      F3_SRL:  return OP_SRL;
      F3_OR:   return OP_OR;
      F3_AND:  return OP_AND;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two combinational read ports, one write port, x0 reads as zero.
// Writes land at the clock edge; no backpressure.
module alu_issue_regfile #(
  parameter int N     = 3,
  parameter int NREGS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [N:0] wdata,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  output logic [N:0] rdata1,
  output logic [N:0] rdata2
);

  logic [N:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand fetch ahead of the ALU, 1-cycle instr->alu_* latency; stalls on RAW via a busy scoreboard
// and holds the output bundle while out_ready=0. ALU_ISSUE_FORWARD_EN enables writeback-to-operand bypass.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int N     = 3,
  parameter int NREGS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  alu_op,
  output logic [N:0]  alu_src1,
  output logic [N:0]  alu_src2,
  output logic [4:0]  alu_rd,
  output logic        illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [N:0]  wb_data
);

  localparam int W = N + 1;

  dec_t             dec;
  logic             is_r;
  logic             wb_act;
  logic             byp1, byp2;
  logic             busy1, busy2, hz;
  logic             fire;
  logic [N:0]       rd1, rd2, src1, src2, imm_ext;
  logic [NREGS-1:0] busy, busy_nxt;

  always_comb begin
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.imm     = instr[31:20];
    dec.op      = f3_to_op(instr[14:12]);
    case (instr[6:0])
      OPC_R: dec.legal = (instr[31:25] == F7_BASE) && f3_supported(instr[14:12]);
      OPC_I: begin
        dec.use_imm = 1'b1;
        // SRLI is only legal with a clean upper immediate (SRAI is not supported).
        dec.legal   = f3_supported(instr[14:12]) &&
                      ((instr[14:12] != F3_SRL) || (instr[31:25] == F7_BASE));
      end
      default: dec.legal = 1'b0;
    endcase
  end

  assign is_r    = (instr[6:0] == OPC_R);
  assign imm_ext = W'($signed(dec.imm));
  assign wb_act  = wb_en && (wb_rd != 5'd0);

`ifdef ALU_ISSUE_FORWARD_EN
  assign byp1 = wb_act && (wb_rd == dec.rs1);
  assign byp2 = wb_act && (wb_rd == dec.rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign busy1    = busy[dec.rs1] && (dec.rs1 != 5'd0) && !byp1;
  assign busy2    = busy[dec.rs2] && (dec.rs2 != 5'd0) && !byp2;
  assign hz       = busy1 || (is_r && busy2);
  assign in_ready = !hz && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  alu_issue_regfile #(
    .N     (N),
    .NREGS (NREGS)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (dec.rs1),
    .raddr2 (dec.rs2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  assign src1 = byp1 ? wb_data : rd1;
  assign src2 = dec.use_imm ? imm_ext : (byp2 ? wb_data : rd2);

  // Clear before set so an issue to the register being written back stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_act) busy_nxt[wb_rd] = 1'b0;
    if (fire && dec.legal && (dec.rd != 5'd0)) busy_nxt[dec.rd] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      alu_op    <= OP_ADD;
      alu_src1  <= '0;
      alu_src2  <= '0;
      alu_rd    <= 5'd0;
      busy      <= '0;
    end else begin
      illegal <= fire && !dec.legal;
      busy    <= busy_nxt;
      if (fire && dec.legal) begin
        out_valid <= 1'b1;
        alu_op    <= dec.op;
        alu_src1  <= src1;
        alu_src2  <= src2;
        alu_rd    <= dec.rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scenarios then randomized traffic against an array-based model of the issue stage.
// Honours ALU_ISSUE_FORWARD_EN so expectations track the build configuration.
module tb_alu_issue_stage;

    localparam int N = 3;
    localparam int W = N + 1;
`ifdef ALU_ISSUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, in_valid, out_ready, wb_en;
    logic [31:0] instr;
    logic [4:0]  wb_rd;
    logic [N:0]  wb_data;
    logic        in_ready, out_valid, illegal;
    logic [2:0]  alu_op;
    logic [N:0]  alu_src1, alu_src2;
    logic [4:0]  alu_rd;

    always #5 clock = ~clock;

    alu_issue_stage #(.N(N), .NREGS(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .alu_rd    (alu_rd),
        .illegal   (illegal),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    int checks   = 0;
    int failures = 0;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s: observed %0h required %0h", tag, (obs), (exp)); end end

    logic [N:0] mregs [32];
    bit         mbusy [32];
    bit         m_ov, m_ill;
    int         m_op;
    logic [N:0] m_s1, m_s2;
    logic [4:0] m_rd;
    int         wbq [$];

    function automatic logic [31:0] enc_r(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic void mdec(input logic [31:0] w, output bit legal, output bit rform,
                                 output int op, output logic [N:0] imm);
        logic [2:0]  f3;
        logic [11:0] i12;
        f3    = w[14:12];
        i12   = w[31:20];
        rform = (w[6:0] == 7'h33);
        imm   = i12[N:0];
        case (f3)
            3'd0:    op = 0;
            3'd5:    op = 1;
            3'd6:    op = 2;
            3'd7:    op = 3;
            default: op = -1;
        endcase
        legal = (op >= 0) &&
                ((rform && w[31:25] == 7'd0) ||
                 (w[6:0] == 7'h13 && (f3 != 3'd5 || w[31:25] == 7'd0)));
    endfunction

    function automatic bit busy_now(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (FWD && wb_en && wb_rd == r) return 1'b0;
        return mbusy[r];
    endfunction

    function automatic logic [N:0] rdval(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (FWD && wb_en && wb_rd == r) return wb_data;
        return mregs[r];
    endfunction

    function automatic bit m_ready();
        bit legal, rf;
        int op;
        logic [N:0] imm;
        mdec(instr, legal, rf, op, imm);
        return !(busy_now(instr[19:15]) || (rf && busy_now(instr[24:20]))) && (!m_ov || out_ready);
    endfunction

    task automatic model_edge();
        bit legal, rf, fire;
        int op;
        logic [N:0] imm;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
            m_ov = 0; m_ill = 0; m_op = 0; m_s1 = '0; m_s2 = '0; m_rd = '0;
            return;
        end
        mdec(instr, legal, rf, op, imm);
        fire = in_valid && m_ready();
        if (m_ov && out_ready && m_rd != 5'd0) wbq.push_back(int'(m_rd));
        m_ill = fire && !legal;
        if (fire && legal) begin
            m_ov = 1;
            m_op = op;
            m_s1 = rdval(instr[19:15]);
            m_s2 = rf ? rdval(instr[24:20]) : imm;
            m_rd = instr[11:7];
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (wb_en && wb_rd != 5'd0) begin mregs[wb_rd] = wb_data; mbusy[wb_rd] = 1'b0; end
        if (fire && legal && instr[11:7] != 5'd0) mbusy[instr[11:7]] = 1'b1;
    endtask

    task automatic cycle();
        #1;
        if (!reset) `CHK("in_ready", in_ready, m_ready())
        @(posedge clock);
        model_edge();
        @(negedge clock);
        `CHK("out_valid", out_valid, m_ov)
        `CHK("illegal", illegal, m_ill)
        if (m_ov) begin
            `CHK("alu_op", alu_op, 3'(m_op))
            `CHK("alu_src1", alu_src1, m_s1)
            `CHK("alu_src2", alu_src2, m_s2)
            `CHK("alu_rd", alu_rd, m_rd)
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic [11:0] imm;
        k = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0:       f3 = 3'd0;
            1:       f3 = 3'd5;
            2:       f3 = 3'd6;
            default: f3 = 3'd7;
        endcase
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        if (k < 4) return enc_r(f3, rd, rs1, rs2);
        if (k < 8) begin
            if (f3 == 3'd5) imm[11:5] = 7'd0;
            return enc_i(f3, rd, rs1, imm);
        end
        if (k == 8) return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
        return 32'($urandom);
    endfunction

    int cnt;

    initial begin
        reset = 1; in_valid = 0; instr = '0; out_ready = 1; wb_en = 0; wb_rd = '0; wb_data = '0;
        @(negedge clock);
        cycle();
        cycle();
        `CHK("rst_op", alu_op, 3'd0)
        `CHK("rst_src1", alu_src1, W'(0))
        `CHK("rst_src2", alu_src2, W'(0))
        `CHK("rst_rd", alu_rd, 5'd0)
        checks++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || alu_op !== 3'd0 ||
            alu_src1 !== W'(0) || alu_src2 !== W'(0) || alu_rd !== 5'd0) begin
            failures++;
            $error("FAIL reset_state: out_valid=%0b illegal=%0b op=%0h src1=%0h src2=%0h rd=%0h",
                   out_valid, illegal, alu_op, alu_src1, alu_src2, alu_rd);
        end
        reset = 0;

        in_valid = 1; instr = enc_i(3'd0, 5'd1, 5'd0, 12'd5);
        cycle();
        `CHK("addi_valid", out_valid, 1'b1)
        `CHK("addi_op", alu_op, 3'd0)
        `CHK("addi_src2", alu_src2, W'(5))
        `CHK("addi_rd", alu_rd, 5'd1)

        instr = enc_i(3'd0, 5'd1, 5'd0, 12'd3);
        cycle();
        instr = enc_r(3'd0, 5'd2, 5'd1, 5'd1);
        cycle();
        `CHK("raw_stall", in_ready, 1'b0)
        wb_en = 1; wb_rd = 5'd1; wb_data = W'(3); cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            wb_en = 0;
            if (cnt == 0 && out_valid && alu_rd == 5'd2) begin
                cnt = k;
                in_valid = 0;
                `CHK("raw_src1", alu_src1, W'(3))
                `CHK("raw_src2", alu_src2, W'(3))
            end
        end
        in_valid = 0;
        checks++;
        if (cnt == 0) begin
            failures++;
            $error("FAIL raw_wait: dependent ADD never issued within 5 cycles after writeback");
        end
        `CHK("raw_issue_delay", cnt, FWD ? 1 : 2)

        in_valid = 1; instr = 32'h0000_0000;
        cycle();
        `CHK("ill_pulse", illegal, 1'b1)
        `CHK("ill_noissue", out_valid, 1'b0)
        instr = enc_i(3'd0, 5'd6, 5'd2, 12'd1);
        #1 `CHK("ill_sb_kept", in_ready, 1'b0)
        cycle();
        `CHK("ill_one_shot", illegal, 1'b0)

        instr = enc_i(3'd0, 5'd7, 5'd0, 12'd6);
        cycle();
        out_ready = 0; instr = enc_i(3'd0, 5'd8, 5'd0, 12'd4);
        for (int k = 0; k < 3; k++) begin
            cycle();
            `CHK("hold_src2", alu_src2, W'(6))
            `CHK("hold_rd", alu_rd, 5'd7)
        end
        out_ready = 1;
        #1 `CHK("release_ready", in_ready, 1'b1)
        cycle();
        `CHK("release_rd", alu_rd, 5'd8)
        in_valid = 0;

        wb_en = 1; wb_rd = 5'd1; wb_data = W'(15);
        cycle();
        wb_en = 0; in_valid = 1; instr = enc_i(3'd5, 5'd3, 5'd1, 12'd2);
        cycle();
        `CHK("srli_op", alu_op, 3'd1)
        `CHK("srli_src1", alu_src1, W'(15))
        `CHK("srli_src2", alu_src2, W'(2))
        instr = enc_i(3'd7, 5'd4, 5'd1, 12'hFFF);
        cycle();
        `CHK("andi_op", alu_op, 3'd3)
        `CHK("andi_src2", alu_src2, W'(15))

        in_valid = 0; wb_en = 1; wb_rd = 5'd0; wb_data = W'(10);
        cycle();
        wb_en = 0; in_valid = 1; instr = enc_r(3'd0, 5'd5, 5'd0, 5'd0);
        cycle();
        `CHK("x0_src1", alu_src1, W'(0))
        `CHK("x0_src2", alu_src2, W'(0))

        instr = enc_i(3'd0, 5'd9, 5'd0, 12'd1); wb_en = 1; wb_rd = 5'd9; wb_data = W'(7);
        cycle();
        wb_en = 0; out_ready = 0; instr = enc_r(3'd0, 5'd10, 5'd9, 5'd0);
        #1 `CHK("set_wins", in_ready, 1'b0)
        `CHK("pre_reset_valid", out_valid, 1'b1)
        reset = 1; in_valid = 0;
        cycle();
        `CHK("reset_drop", out_valid, 1'b0)
        reset = 0; out_ready = 1; in_valid = 1;
        #1 `CHK("reset_sb_clear", in_ready, 1'b1)
        cycle();

        reset = 1; in_valid = 0;
        cycle();
        reset = 0;
        wbq.delete();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            instr     = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            if (wbq.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_en   = 1;
                wb_rd   = 5'(wbq.pop_front());
                wb_data = W'($urandom);
            end else begin
                wb_en = 0;
            end
            cycle();
            checks++;
            if (out_valid !== m_ov) begin
                failures++;
                $error("FAIL rnd_out_valid: observed %0b required %0b", out_valid, m_ov);
            end
            checks++;
            if (illegal !== m_ill) begin
                failures++;
                $error("FAIL rnd_illegal: observed %0b required %0b", illegal, m_ill);
            end
            if (m_ov) begin
                checks++;
                if (alu_rd !== m_rd) begin
                    failures++;
                    $error("FAIL rnd_alu_rd: observed %0h required %0h", alu_rd, m_rd);
                end
                checks++;
                if (alu_src1 !== m_s1) begin
                    failures++;
                    $error("FAIL rnd_alu_src1: observed %0h required %0h", alu_src1, m_s1);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
